// File: rtl/postadder_normalizer_pkg.sv
// Shared definitions for the FP add/sub back end: default widths, FSM encodings
// and bit positions inside the {carry, hidden, fraction, guard, round} mantissa.
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

package postadder_normalizer_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_NORM  = 2'd1;
   localparam logic [1:0] ST_ROUND = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int ROUND_BIT = 0;
   localparam int GUARD_BIT = 1;
   localparam int LSB_BIT   = 2;

   function automatic int hidden_pos(input int mantis_size);
      return mantis_size + 2;
   endfunction

   function automatic int carry_pos(input int mantis_size);
      return mantis_size + 3;
   endfunction

endpackage

// File: rtl/postadder_rounder.sv
// Round-to-nearest-even on a {hidden, fraction} significand; round_carry flags
// the increment rippling out of the hidden bit.
module postadder_rounder #(
   parameter int MANTIS_SIZE = 23
) (
   input  logic [MANTIS_SIZE:0] i_hf,
   input  logic                 i_guard,
   input  logic                 i_round,
   input  logic                 i_sticky,
   output logic [MANTIS_SIZE:0] o_hf,
   output logic                 o_round_carry
);

   logic w_inc;

   // Ties (guard set, nothing below) only round up when the lsb is odd.
   assign w_inc = i_guard & (i_round | i_sticky | i_hf[0]);
   assign {o_round_carry, o_hf} = {1'b0, i_hf} + {{(MANTIS_SIZE + 1){1'b0}}, w_inc};

endmodule

// File: rtl/postadder_normalizer.sv
// Post-adder normaliser: one-bit-per-cycle normalisation, RNE rounding and
// special-case packing, with a single operation in flight between handshakes.
module postadder_normalizer
   import postadder_normalizer_pkg::*;
#(
   parameter int EXP_SIZE    = `EXP_SIZE,
   parameter int MANTIS_SIZE = `MANTIS_SIZE
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sign,
   input  logic [EXP_SIZE-1:0]    in_exp,
   input  logic [MANTIS_SIZE+3:0] in_mantis,
   input  logic                   in_loss,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_sign,
   output logic [EXP_SIZE-1:0]    out_exp,
   output logic [MANTIS_SIZE-1:0] out_frac,
   output logic                   out_zero,
   output logic                   out_overflow,
   output logic                   out_underflow
);

   localparam int MW       = MANTIS_SIZE + 4;
   localparam int P_CARRY  = carry_pos(MANTIS_SIZE);
   localparam int P_HIDDEN = hidden_pos(MANTIS_SIZE);
   localparam logic [EXP_SIZE-1:0] EXP_MAX = {EXP_SIZE{1'b1}};

   logic [1:0]             r_state;
   logic                   r_sign;
   logic [EXP_SIZE-1:0]    r_exp;
   logic [MW-1:0]          r_mant;
   logic                   r_sticky;

   logic                   r_osign;
   logic [EXP_SIZE-1:0]    r_oexp;
   logic [MANTIS_SIZE-1:0] r_ofrac;
   logic                   r_ozero;
   logic                   r_oovf;
   logic                   r_ounf;

   logic [EXP_SIZE-1:0]    w_exp_inc;
   logic [EXP_SIZE-1:0]    w_exp_dec;
   logic                   w_exp_le1;
   logic [MANTIS_SIZE:0]   w_hf;
   logic                   w_rc;
   logic                   w_unused_hidden;

   logic                   w_go;
   logic                   w_nsign;
   logic [EXP_SIZE-1:0]    w_nexp;
   logic [MANTIS_SIZE-1:0] w_nfrac;
   logic                   w_nz;
   logic                   w_no;
   logic                   w_nu;

   assign w_exp_inc = r_exp + 1'b1;
   assign w_exp_dec = r_exp - 1'b1;
   assign w_exp_le1 = (r_exp[EXP_SIZE-1:1] == '0);

   postadder_rounder #(.MANTIS_SIZE(MANTIS_SIZE)) u_rounder (
      .i_hf          (r_mant[P_HIDDEN:LSB_BIT]),
      .i_guard       (r_mant[GUARD_BIT]),
      .i_round       (r_mant[ROUND_BIT]),
      .i_sticky      (r_sticky),
      .o_hf          (w_hf),
      .o_round_carry (w_rc)
   );

   // On a round carry the fraction bits are already zero; only the exponent moves.
   assign w_unused_hidden = w_hf[MANTIS_SIZE];

   // Result to publish when the FSM enters DONE this cycle.
   always_comb begin
      w_go    = 1'b0;
      w_nsign = r_sign;
      w_nexp  = r_exp;
      w_nfrac = w_hf[MANTIS_SIZE-1:0];
      w_nz    = 1'b0;
      w_no    = 1'b0;
      w_nu    = 1'b0;
      case (r_state)
         ST_NORM: begin
            if (r_mant[P_CARRY]) begin
               if (w_exp_inc == EXP_MAX) begin
                  w_go    = 1'b1;
                  w_nexp  = EXP_MAX;
                  w_nfrac = '0;
                  w_no    = 1'b1;
               end
            end else if (r_mant == '0) begin
               w_go    = 1'b1;
               w_nsign = 1'b0;
               w_nexp  = '0;
               w_nfrac = '0;
               w_nz    = 1'b1;
            end else if (!r_mant[P_HIDDEN] && w_exp_le1) begin
               w_go    = 1'b1;
               w_nsign = 1'b0;
               w_nexp  = '0;
               w_nfrac = '0;
               w_nu    = 1'b1;
            end
         end
         ST_ROUND: begin
            w_go = 1'b1;
            if (w_rc) begin
               w_nexp = w_exp_inc;
               if (w_exp_inc == EXP_MAX) begin
                  w_nfrac = '0;
                  w_no    = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_sign   <= 1'b0;
         r_exp    <= '0;
         r_mant   <= '0;
         r_sticky <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_sign   <= in_sign;
                  r_exp    <= in_exp;
                  r_mant   <= in_mantis;
                  r_sticky <= in_loss;
                  r_state  <= ST_NORM;
               end
            end
            ST_NORM: begin
               if (r_mant[P_CARRY]) begin
                  r_mant   <= r_mant >> 1;
                  r_sticky <= r_sticky | r_mant[0];
                  r_exp    <= w_exp_inc;
                  r_state  <= w_go ? ST_DONE : ST_ROUND;
               end else if (w_go) begin
                  r_state <= ST_DONE;
               end else if (r_mant[P_HIDDEN]) begin
                  r_state <= ST_ROUND;
               end else begin
                  r_mant <= r_mant << 1;
                  r_exp  <= w_exp_dec;
               end
            end
            ST_ROUND: r_state <= ST_DONE;
            default: begin
               if (out_ready) r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_osign <= 1'b0;
         r_oexp  <= '0;
         r_ofrac <= '0;
         r_ozero <= 1'b0;
         r_oovf  <= 1'b0;
         r_ounf  <= 1'b0;
      end else if (w_go) begin
         r_osign <= w_nsign;
         r_oexp  <= w_nexp;
         r_ofrac <= w_nfrac;
         r_ozero <= w_nz;
         r_oovf  <= w_no;
         r_ounf  <= w_nu;
      end
   end

   assign in_ready      = (r_state == ST_IDLE);
   assign out_valid     = (r_state == ST_DONE);
   assign out_sign      = r_osign;
   assign out_exp       = r_oexp;
   assign out_frac      = r_ofrac;
   assign out_zero      = r_ozero;
   assign out_overflow  = r_oovf;
   assign out_underflow = r_ounf;

endmodule

// File: tb/tb_postadder_normalizer.sv
// Directed + randomized bench for postadder_normalizer against a value-level
// reference model (normalise by leading-one position, round by remainder size).
module tb_postadder_normalizer;

   localparam int E = 8;
   localparam int M = 23;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_sign = 1'b0;
   logic [E-1:0]  in_exp = '0;
   logic [M+3:0]  in_mantis = '0;
   logic          in_loss = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_sign;
   logic [E-1:0]  out_exp;
   logic [M-1:0]  out_frac;
   logic          out_zero;
   logic          out_overflow;
   logic          out_underflow;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   typedef struct {
      bit s;
      int e;
      int f;
      bit z;
      bit o;
      bit u;
      int lat;
   } res_t;

   postadder_normalizer #(.EXP_SIZE(E), .MANTIS_SIZE(M)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sign       (in_sign),
      .in_exp        (in_exp),
      .in_mantis     (in_mantis),
      .in_loss       (in_loss),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_sign      (out_sign),
      .out_exp       (out_exp),
      .out_frac      (out_frac),
      .out_zero      (out_zero),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Value-level model: position of the leading one decides the shift count,
   // the two dropped bits plus sticky decide rounding by comparison to a half ulp.
   function automatic res_t model(input bit s, input int e, input bit [M+3:0] m, input bit loss);
      res_t   r;
      int     p;
      int     k;
      int     ee;
      bit     st;
      longint sig;
      longint q;
      longint twice;
      r = '{s: 1'b0, e: 0, f: 0, z: 1'b0, o: 1'b0, u: 1'b0, lat: 0};
      if (m == 0) begin
         r.z = 1'b1; r.lat = 2;
         return r;
      end
      p = 0;
      for (int i = 0; i < M + 4; i++) if (m[i]) p = i;
      st = loss; ee = e; sig = longint'(m); k = 0;
      if (p == M + 3) begin
         st  = st | m[0];
         sig = sig >> 1;
         ee  = e + 1;
         if (ee == 255) begin
            r.s = s; r.e = 255; r.o = 1'b1; r.lat = 2;
            return r;
         end
      end else if (p < M + 2) begin
         k = M + 2 - p;
         if (e - k < 1) begin
            r.u = 1'b1; r.lat = 2 + ((e > 1) ? e - 1 : 0);
            return r;
         end
         sig = sig << k;
         ee  = e - k;
      end
      q     = sig >> 2;
      twice = (sig & 3) * 2 + longint'(st);
      if (twice > 4 || (twice == 4 && q[0])) q = q + 1;
      if (q == (longint'(1) << (M + 1))) begin
         q  = longint'(1) << M;
         ee = ee + 1;
      end
      r.lat = 3 + k;
      if (ee == 255) begin
         r.s = s; r.e = 255; r.o = 1'b1;
      end else begin
         r.s = s; r.e = ee; r.f = int'(q & ((longint'(1) << M) - 1));
      end
      return r;
   endfunction

   // Entered and left at #1 after a rising edge. hold>0 keeps out_ready low
   // for that many cycles while offering a second, to-be-ignored operation.
   task automatic run_op(input string tag, input bit s, input int e, input bit [M+3:0] m,
                         input bit loss, input int hold);
      res_t x;
      int   edges;
      x = model(s, e, m, loss);
      in_sign = s; in_exp = E'(e); in_mantis = m; in_loss = loss; in_valid = 1'b1;
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
      chk({tag, ".latency"},   64'(edges),         64'(x.lat));
      chk({tag, ".sign"},      64'(out_sign),      64'(x.s));
      chk({tag, ".exp"},       64'(out_exp),       64'(x.e));
      chk({tag, ".frac"},      64'(out_frac),      64'(x.f));
      chk({tag, ".zero"},      64'(out_zero),      64'(x.z));
      chk({tag, ".overflow"},  64'(out_overflow),  64'(x.o));
      chk({tag, ".underflow"}, 64'(out_underflow), 64'(x.u));
      if (hold > 0) begin
         in_valid = 1'b1; in_sign = ~s; in_exp = 8'd77; in_mantis = 27'h3000003; in_loss = 1'b1;
         for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, ".hold_ready"}, 64'(in_ready),  64'(0));
            chk({tag, ".hold_exp"},   64'(out_exp),   64'(x.e));
            chk({tag, ".hold_frac"},  64'(out_frac),  64'(x.f));
         end
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".handoff_valid"}, 64'(out_valid), 64'(0));
      chk({tag, ".handoff_ready"}, 64'(in_ready),  64'(1));
      if (hold > 0) begin
         repeat (4) @(posedge clk);
         #1;
         chk({tag, ".ignored_valid"}, 64'(out_valid), 64'(0));
         chk({tag, ".ignored_ready"}, 64'(in_ready),  64'(1));
      end
   endtask

   initial begin
      bit [M+3:0] m;
      int         p;
      int         e;
      longint     one;
      one = 1;

      #1;
      chk("reset.in_ready",  64'(in_ready),      64'(1));
      chk("reset.out_valid", 64'(out_valid),     64'(0));
      chk("reset.exp",       64'(out_exp),       64'(0));
      chk("reset.frac",      64'(out_frac),      64'(0));
      chk("reset.flags",     64'({out_sign, out_zero, out_overflow, out_underflow}), 64'(0));
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("carry",     1'b0, 127, 27'h6000000, 1'b0, 0);
      run_op("cancel",    1'b1, 127, 27'h0000004, 1'b0, 0);
      run_op("tie_even",  1'b0, 100, 27'h2000006, 1'b0, 0);
      run_op("tie_loss",  1'b0, 100, 27'h2000004, 1'b1, 0);
      run_op("rnd_ovf",   1'b0, 100, 27'h3FFFFFE, 1'b0, 0);
      run_op("zero",      1'b1, 55,  27'h0000000, 1'b1, 0);
      run_op("norm_ovf",  1'b1, 254, 27'h4000000, 1'b0, 0);
      run_op("rnd_inf",   1'b1, 254, 27'h3FFFFFE, 1'b1, 0);
      run_op("underflow", 1'b1, 3,   27'h0000004, 1'b0, 0);
      run_op("hold",      1'b1, 90,  27'h1234567, 1'b1, 5);

      // Asynchronous reset while normalising a long cancellation.
      in_sign = 1'b0; in_exp = 8'd127; in_mantis = 27'h0000004; in_loss = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset.in_ready",  64'(in_ready),  64'(1));
      chk("midreset.out_valid", 64'(out_valid), 64'(0));
      chk("midreset.exp",       64'(out_exp),   64'(0));
      #3 rst_n = 1'b1;
      repeat (30) begin
         @(posedge clk); #1;
         chk("midreset.no_pulse", 64'(out_valid), 64'(0));
      end
      run_op("post_reset", 1'b1, 127, 27'h6000000, 1'b1, 0);

      for (int i = 0; i < 40; i++) begin
         p = $urandom_range(0, M + 4);
         if (p == M + 4) m = '0;
         else m = (M + 4)'((longint'($urandom) & ((one << p) - 1)) | (one << p));
         if ($urandom_range(0, 3) == 0) m[0] = 1'b0;
         e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 254);
         run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), e, m,
                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 2 : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
